// File: rtl/peak_detect.sv
// peak_detect: streaming spectral peak finder.
// Takes one FFT output packet per frame (sop/eop/valid framing, signed re/im) and reports
// the positive-frequency bin 1..N/2-1 with the largest power re^2+im^2. Never back-pressures.
//
// Ports:
//   clk, reset                      clock and asynchronous active-low reset
//   sink_sop/eop/valid              packet framing; sop/eop are qualified by sink_valid
//   sink_re, sink_im                signed FFT sample
//   source_valid                    one-cycle pulse: result fields below are valid
//   source_error                    one-cycle pulse: malformed frame was discarded
//   source_bin/re/im/mag            peak bin, its complex value and its power (held between results)
module peak_detect #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sink_sop,
    input  logic                 sink_eop,
    input  logic                 sink_valid,
    input  logic [WIDTH-1:0]     sink_re,
    input  logic [WIDTH-1:0]     sink_im,
    output logic                 source_valid,
    output logic                 source_error,
    output logic [DEPTH-1:0]     source_bin,
    output logic [WIDTH-1:0]     source_re,
    output logic [WIDTH-1:0]     source_im,
    output logic [2*WIDTH-1:0]   source_mag
);

    localparam int unsigned MW = 2 * WIDTH;
    localparam logic [DEPTH-1:0] BinOne  = DEPTH'(1);
    localparam logic [DEPTH-1:0] BinLast = '1;

    typedef enum logic [0:0] {StIdle, StFrame} state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] cnt_q, cnt_d;

    // Per-beat tags decoded from the framing state
    logic [DEPTH-1:0] beat_bin;
    logic             beat_cand, beat_eof, beat_err;

    // ---------------- Framing FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sink_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (sink_sop && !sink_eop) begin
                        state_d = StFrame;
                        cnt_d   = BinOne;
                    end
                end
                StFrame: begin
                    if (sink_sop) begin
                        // Abort and restart on this beat as bin 0
                        if (sink_eop) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = BinOne;
                        end
                    end else if (sink_eop || cnt_q == BinLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + BinOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        beat_bin = (state_q == StFrame && !sink_sop) ? cnt_q : '0;
        beat_eof = 1'b0;
        beat_err = 1'b0;
        if (sink_valid) begin
            unique case (state_q)
                StIdle:  beat_err = sink_sop & sink_eop;
                StFrame: begin
                    if (sink_sop) begin
                        beat_err = 1'b1;
                    end else if (cnt_q == BinLast) begin
                        beat_eof = sink_eop;
                        beat_err = !sink_eop;
                    end else begin
                        beat_err = sink_eop;
                    end
                end
                default: beat_err = 1'b0;
            endcase
        end
        // DC and the mirrored upper half are never candidates
        beat_cand = sink_valid && (beat_bin != '0) && !beat_bin[DEPTH-1];
    end

    // ---------------- Pipeline ----------------
    // s0: tagged input beat
    logic             s0_cand_q, s0_eof_q, s0_err_q;
    logic [DEPTH-1:0] s0_bin_q;
    logic [WIDTH-1:0] s0_re_q, s0_im_q;
    // s1: squared components
    logic             s1_cand_q, s1_eof_q, s1_err_q;
    logic [DEPTH-1:0] s1_bin_q;
    logic [WIDTH-1:0] s1_re_q, s1_im_q;
    logic [MW-1:0]    s1_pre_q, s1_pim_q;
    // s2: power
    logic             s2_cand_q, s2_eof_q, s2_err_q;
    logic [DEPTH-1:0] s2_bin_q;
    logic [WIDTH-1:0] s2_re_q, s2_im_q;
    logic [MW-1:0]    s2_mag_q;
    // s3: compare/update, plus the terminating flags that trigger the output stage
    logic             s3_eof_q, s3_err_q;
    logic [DEPTH-1:0] best_bin_q;
    logic [WIDTH-1:0] best_re_q, best_im_q;
    logic [MW-1:0]    best_mag_q;
    // output stage
    logic             out_valid_q, out_error_q;
    logic [DEPTH-1:0] out_bin_q;
    logic [WIDTH-1:0] out_re_q, out_im_q;
    logic [MW-1:0]    out_mag_q;

    // Sign-extend to full width so the products are exact without mixed-width multiplies
    logic signed [MW-1:0] re_ext, im_ext;
    assign re_ext = {{WIDTH{s0_re_q[WIDTH-1]}}, s0_re_q};
    assign im_ext = {{WIDTH{s0_im_q[WIDTH-1]}}, s0_im_q};

    logic load_best;
    assign load_best = s2_cand_q && (s2_bin_q == BinOne || s2_mag_q > best_mag_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_cand_q   <= 1'b0;
            s0_eof_q    <= 1'b0;
            s0_err_q    <= 1'b0;
            s0_bin_q    <= '0;
            s0_re_q     <= '0;
            s0_im_q     <= '0;
            s1_cand_q   <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_bin_q    <= '0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_pre_q    <= '0;
            s1_pim_q    <= '0;
            s2_cand_q   <= 1'b0;
            s2_eof_q    <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_bin_q    <= '0;
            s2_re_q     <= '0;
            s2_im_q     <= '0;
            s2_mag_q    <= '0;
            s3_eof_q    <= 1'b0;
            s3_err_q    <= 1'b0;
            best_bin_q  <= '0;
            best_re_q   <= '0;
            best_im_q   <= '0;
            best_mag_q  <= '0;
            out_valid_q <= 1'b0;
            out_error_q <= 1'b0;
            out_bin_q   <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_mag_q   <= '0;
        end else begin
            s0_cand_q <= beat_cand;
            s0_eof_q  <= beat_eof;
            s0_err_q  <= beat_err;
            s0_bin_q  <= beat_bin;
            s0_re_q   <= sink_re;
            s0_im_q   <= sink_im;

            s1_cand_q <= s0_cand_q;
            s1_eof_q  <= s0_eof_q;
            s1_err_q  <= s0_err_q;
            s1_bin_q  <= s0_bin_q;
            s1_re_q   <= s0_re_q;
            s1_im_q   <= s0_im_q;
            s1_pre_q  <= MW'(re_ext * re_ext);
            s1_pim_q  <= MW'(im_ext * im_ext);

            s2_cand_q <= s1_cand_q;
            s2_eof_q  <= s1_eof_q;
            s2_err_q  <= s1_err_q;
            s2_bin_q  <= s1_bin_q;
            s2_re_q   <= s1_re_q;
            s2_im_q   <= s1_im_q;
            s2_mag_q  <= s1_pre_q + s1_pim_q;

            s3_eof_q  <= s2_eof_q;
            s3_err_q  <= s2_err_q;
            // Bin 1 reloads unconditionally, so a stale best never leaks across frames
            if (load_best) begin
                best_bin_q <= s2_bin_q;
                best_re_q  <= s2_re_q;
                best_im_q  <= s2_im_q;
                best_mag_q <= s2_mag_q;
            end

            out_valid_q <= s3_eof_q;
            out_error_q <= s3_err_q;
            if (s3_eof_q) begin
                out_bin_q <= best_bin_q;
                out_re_q  <= best_re_q;
                out_im_q  <= best_im_q;
                out_mag_q <= best_mag_q;
            end
        end
    end

    assign source_valid = out_valid_q;
    assign source_error = out_error_q;
    assign source_bin   = out_bin_q;
    assign source_re    = out_re_q;
    assign source_im    = out_im_q;
    assign source_mag   = out_mag_q;

endmodule

// File: tb/tb_peak_detect.sv
// Self-checking bench for peak_detect (WIDTH=8, DEPTH=4, N=16).
// A frame-level reference model decides, per sampled beat, whether a result or error is due
// four edges later; the compare step checks every DUT output on every falling edge.
module tb_peak_detect;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sink_sop = 1'b0, sink_eop = 1'b0, sink_valid = 1'b0;
    logic [W-1:0] sink_re = '0, sink_im = '0;
    logic         source_valid, source_error;
    logic [D-1:0] source_bin;
    logic [W-1:0] source_re, source_im;
    logic [2*W-1:0] source_mag;

    always #5 clk = ~clk;

    peak_detect #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_valid   (sink_valid),
        .sink_re      (sink_re),
        .sink_im      (sink_im),
        .source_valid (source_valid),
        .source_error (source_error),
        .source_bin   (source_bin),
        .source_re    (source_re),
        .source_im    (source_im),
        .source_mag   (source_mag)
    );

    typedef struct {
        int due;
        bit err;
        int bin;
        int re;
        int im;
        int mag;
    } ev_t;

    ev_t evq[$];
    int  rd = 0;
    int  ec = 0;
    int  nvec = 0, nerr = 0;
    int  mst = 0, midx = 0;
    int  mre[N], mim[N];
    int  hb = 0, hre = 0, him = 0, hm = 0;
    int  vcnt = 0, ecnt = 0;
    int  vedge[$];
    int  res_log[$];
    int  fre[N], fim[N];

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ec);
        end
    endtask

    function automatic int mmag(input int b);
        return mre[b] * mre[b] + mim[b] * mim[b];
    endfunction

    task automatic push_err();
        evq.push_back('{ec + 4, 1'b1, 0, 0, 0, 0});
    endtask

    // Peak of the positive half: first bin holding the strict maximum power
    task automatic push_res();
        int best = 1;
        for (int b = 2; b < N / 2; b++) if (mmag(b) > mmag(best)) best = b;
        evq.push_back('{ec + 4, 1'b0, best, mre[best], mim[best], mmag(best)});
        res_log.push_back(best);
    endtask

    task automatic model_step();
        int r, i;
        ec++;
        if (!reset) begin
            mst = 0;
            midx = 0;
        end else if (sink_valid) begin
            r = int'($signed(sink_re));
            i = int'($signed(sink_im));
            if (mst == 0) begin
                if (sink_sop) begin
                    mre[0] = r; mim[0] = i;
                    if (sink_eop) push_err();
                    else begin mst = 1; midx = 1; end
                end
            end else if (sink_sop) begin
                push_err();
                mre[0] = r; mim[0] = i;
                if (sink_eop) mst = 0;
                else midx = 1;
            end else begin
                mre[midx] = r; mim[midx] = i;
                if (sink_eop) begin
                    if (midx == N - 1) push_res();
                    else push_err();
                    mst = 0;
                end else if (midx == N - 1) begin
                    push_err();
                    mst = 0;
                end else begin
                    midx++;
                end
            end
        end
    endtask

    task automatic compare_step();
        bit ev = 1'b0, ee = 1'b0;
        if (!reset) begin
            rd = evq.size();
            hb = 0; hre = 0; him = 0; hm = 0;
        end else if (rd < evq.size() && evq[rd].due == ec) begin
            if (evq[rd].err) ee = 1'b1;
            else begin
                ev = 1'b1;
                hb = evq[rd].bin; hre = evq[rd].re; him = evq[rd].im; hm = evq[rd].mag;
            end
            rd++;
        end
        chk("valid", source_valid, ev);
        chk("error", source_error, ee);
        chk("bin", source_bin, hb);
        chk("re", $signed(source_re), hre);
        chk("im", $signed(source_im), him);
        chk("mag", source_mag, hm);
        if (source_valid) begin vcnt++; vedge.push_back(ec); end
        if (source_error) ecnt++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_step();
        #1;
    endtask

    task automatic idle(input int n);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic beat(input bit s, input bit e, input int r, input int i, input int gap);
        while (int'($urandom_range(99)) < gap) idle(1);
        sink_valid = 1'b1; sink_sop = s; sink_eop = e;
        sink_re = r[W-1:0]; sink_im = i[W-1:0];
        cyc();
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    task automatic send(input int last, input int eop_at, input int gap);
        for (int b = 0; b <= last; b++) beat(b == 0, b == eop_at, fre[b], fim[b], gap);
    endtask

    task automatic fill_tone(input int pb, input int pr, input int pi);
        for (int b = 0; b < N; b++) begin
            fre[b] = ($urandom_range(1) == 1) ? 3 : -3;
            fim[b] = ($urandom_range(1) == 1) ? 3 : -3;
        end
        fre[pb] = pr; fim[pb] = pi;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, eop_edge, n;
        #1;
        idle(3);
        reset = 1'b1;
        idle(2);

        // Tone at bin 5
        fill_tone(5, 100, -50);
        v0 = vcnt;
        send(15, 15, 0);
        eop_edge = ec;
        idle(6);
        chk("tone_model_bin", res_log[$], 5);
        chk("tone_bin", source_bin, 5);
        chk("tone_re", $signed(source_re), 100);
        chk("tone_im", $signed(source_im), -50);
        chk("tone_mag", source_mag, 12500);
        chk("tone_pulses", vcnt - v0, 1);
        chk("tone_latency", vedge[$] - eop_edge, 4);

        // Tie between bins 3 and 6; mirror and DC bins larger but excluded
        for (int b = 0; b < N; b++) begin fre[b] = 0; fim[b] = 0; end
        fim[3] = 40; fim[6] = 40; fre[11] = 127; fim[11] = 127; fre[0] = -128; fim[0] = -128;
        send(15, 15, 0);
        idle(6);
        chk("tie_model_bin", res_log[$], 3);
        chk("tie_bin", source_bin, 3);
        chk("tie_mag", source_mag, 1600);

        // Tone with 50% valid gaps
        fill_tone(5, 100, -50);
        v0 = vcnt;
        send(15, 15, 50);
        eop_edge = ec;
        idle(6);
        chk("gap_bin", source_bin, 5);
        chk("gap_mag", source_mag, 12500);
        chk("gap_latency", vedge[$] - eop_edge, 4);
        chk("gap_pulses", vcnt - v0, 1);

        // Back-to-back frames, peaks at 2, 7, 1
        v0 = vcnt;
        fill_tone(2, 90, 10);  send(15, 15, 0);
        fill_tone(7, -90, 5);  send(15, 15, 0);
        fill_tone(1, 60, -70); send(15, 15, 0);
        idle(6);
        n = vedge.size();
        chk("b2b_pulses", vcnt - v0, 3);
        chk("b2b_space1", vedge[n-2] - vedge[n-3], 16);
        chk("b2b_space2", vedge[n-1] - vedge[n-2], 16);
        chk("b2b_bin_a", res_log[res_log.size()-3], 2);
        chk("b2b_bin_b", res_log[res_log.size()-2], 7);
        chk("b2b_bin_c", res_log[res_log.size()-1], 1);
        chk("b2b_last_bin", source_bin, 1);

        // Framing errors
        v0 = vcnt; e0 = ecnt;
        fill_tone(6, 50, 50);
        send(9, 9, 0);
        idle(6);
        chk("err_eop9", ecnt - e0, 1);
        chk("err_eop9_noval", vcnt - v0, 0);
        send(3, -1, 0);
        send(15, 15, 0);
        idle(6);
        chk("err_sop4", ecnt - e0, 2);
        chk("err_sop4_val", vcnt - v0, 1);
        chk("err_sop4_bin", source_bin, 6);
        send(15, -1, 0);
        idle(6);
        chk("err_noeop", ecnt - e0, 3);
        for (int k = 0; k < 5; k++) beat(1'b0, k == 4, 20, 20, 0);
        idle(6);
        chk("idle_beats_err", ecnt - e0, 3);
        chk("idle_beats_val", vcnt - v0, 1);

        // Reset in the middle of a frame
        fill_tone(4, -110, 20);
        v0 = vcnt; e0 = ecnt;
        send(8, -1, 0);
        reset = 1'b0;
        idle(3);
        chk("rst_bin_zero", source_bin, 0);
        chk("rst_mag_zero", source_mag, 0);
        reset = 1'b1;
        idle(1);
        send(15, 15, 0);
        idle(6);
        chk("rst_pulses", vcnt - v0, 1);
        chk("rst_errors", ecnt - e0, 0);
        chk("rst_bin", source_bin, 4);
        chk("rst_mag", source_mag, 12500);

        // Randomized frames, data, gaps and framing faults
        for (int f = 0; f < 40; f++) begin
            int kind, k, gap;
            for (int b = 0; b < N; b++) begin
                fre[b] = int'($urandom_range(255)) - 128;
                fim[b] = int'($urandom_range(255)) - 128;
            end
            kind = int'($urandom_range(7));
            k = int'($urandom_range(14, 1));
            gap = int'($urandom_range(50));
            if (kind == 0) send(k, k, gap);
            else if (kind == 1) send(15, -1, gap);
            else if (kind == 2) send(k, -1, gap);
            else send(15, 15, gap);
            idle(int'($urandom_range(2)));
        end
        idle(8);
        chk("drain", evq.size() - rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/peak_detect.md
# peak_detect

Streaming spectral peak finder that consumes one FFT output packet per frame (sop/eop/valid, signed re/im) and reports the positive-frequency bin with the largest power. It sits directly downstream of the FFT in the phase extraction chain, alongside the frequency buffer. Its result (bin index plus complex value) selects the bin whose phase is extracted. It never back-pressures the FFT.

## Interface
- WIDTH, 20: bits per re/im sample, two's complement. Equals the FFT output width.
- DEPTH, 11: FFT levels; frame length N = 2**DEPTH.
- clk  in  1: main processing clock; all logic on rising edge.
- reset  in  1: asynchronous, active-low. 0 clears all state.
- sink_sop  in  1: first beat of packet; qualified by sink_valid.
- sink_eop  in  1: last beat of packet; qualified by sink_valid.
- sink_valid  in  1: beat present this cycle.
- sink_re  in  WIDTH: real part, signed.
- sink_im  in  WIDTH: imaginary part, signed.
- source_valid  out  1: one-cycle pulse; result fields are valid.
- source_error  out  1: one-cycle pulse; malformed frame discarded.
- source_bin  out  DEPTH: index of peak bin.
- source_re  out  WIDTH: real part at peak bin.
- source_im  out  WIDTH: imaginary part at peak bin.
- source_mag  out  2*WIDTH: re²+im² at peak bin, unsigned.

## Operation
- Framing FSM, states IDLE and FRAME. Beats are counted only when sink_valid=1. sink_valid=0 stalls: no state change.
- IDLE: a beat with sop=0 is ignored. A beat with sop=1 is bin 0. If it also has eop=1, raise an error and stay in IDLE. Otherwise go to FRAME with bin counter=1 for the next beat.
- FRAME: each beat takes the current bin index, then the counter increments.
  - Beat with sop=1: abort the current frame, raise an error, and restart with this beat as bin 0. Stay in FRAME.
  - Beat with eop=1 and index = N-1: frame complete, raise result, go to IDLE.
  - Beat with eop=1 and index ≠ N-1: raise an error, go to IDLE.
  - Beat at index N-1 with eop=0: raise an error, go to IDLE.
- Candidates are bins 1 to N/2-1 only. DC and bins ≥ N/2 (mirror of real input) are never reported.
- Power: mag = re*re + im*im, computed exactly in 2*WIDTH unsigned bits with no rounding. The maximum is 2^(2*WIDTH-1), which fits.
- Compare: a candidate replaces the stored best only if its mag is strictly greater. Ties go to the lowest bin. Bin 1 always loads the best register unconditionally, so there is no clear between frames.
- Pipeline, three stages, each tagged with bin index, candidate flag, end-of-frame flag, error flag and re/im:
  - S1 registers the two products.
  - S2 registers the sum.
  - S3 does the compare and update of the best register.
- Result or error is issued from the stage after S3, so errors and results stay in stream order.
- An aborted frame's partial best is overwritten by the next frame's bin 1 and never reported.

## Timing
- Latency: a terminating beat (good eop or error) sampled at edge k makes source_valid or source_error high for exactly the cycle following edge k+4.
- source_valid and source_error are never high together.
- Throughput: one beat per cycle. A new sop may be sampled at edge k+1 after eop. Back-to-back frames each produce a result.
- source_bin, source_re, source_im and source_mag update only with source_valid and hold otherwise. They keep their values on source_error.
- Reset values: source_valid=0, source_error=0, source_bin=0, source_re=0, source_im=0, source_mag=0. FSM=IDLE, counter=0, pipeline tags cleared.
- Reset asserted mid-frame: in-flight beats are dropped and no result or error is emitted for that frame. After release, wait for the next sop.

## Test plan
- Tone, DEPTH=4 (N=16), WIDTH=8: bin 5 = (100,-50), all other bins ±3 -> one source_valid 4 cycles after eop; bin=5, re=100, im=-50, mag=12500.
- Tie and mirror: bins 3 and 6 = (0,40), bin 11 = (127,127), bin 0 = (-128,-128) -> bin=3, mag=1600. Mirror and DC bins are ignored.
- Random sink_valid gaps (50% duty) over the tone frame -> same result as the gapless case. Latency is still measured from the eop beat.
- Back-to-back: three frames with peaks at bins 2, 7 and 1, no idle cycles between them -> three source_valid pulses with bins 2, 7, 1, spaced 16 cycles apart.
- Framing errors: eop at bin 9 -> source_error only. sop at bin 4 followed by a good 16-beat frame -> one error, then a correct result. Missing eop at bin 15 -> error. Non-sop beats in IDLE -> no output.
- Reset low at bin 8, released 3 cycles later, then a full frame with peak at bin 4 -> no output for the aborted frame; bin=4 reported. All outputs are 0 during reset.
